// File: rtl/sm83_timer.sv
// SM83 DIV/TIMA/TMA/TAC timer: bus responder with one-clk overflow irq.
// Ports: clk, rst_n, addr/w_data/w_wen in; r_data/hit/timer_irq out.
module sm83_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          CNT_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [7:0]  w_data,
    input  logic        w_wen,
    output logic [7:0]  r_data,
    output logic        hit,
    output logic        timer_irq
);

    logic [15:0] r_cnt;
    logic [7:0]  r_tima;
    logic [7:0]  r_tma;
    logic [2:0]  r_tac;
    logic        r_ovf;
    logic        r_irq;

    logic [15:0] w_off;
    logic        w_wr_div;
    logic        w_wr_tima;
    logic        w_wr_tma;
    logic        w_wr_tac;
    logic [15:0] w_cnt_next;
    logic [2:0]  w_tac_next;
    logic [7:0]  w_tma_next;
    logic        w_tick;
    logic [7:0]  w_tima_next;
    logic        w_ovf_next;
    logic        w_irq_next;

    // Timer input: selected counter bit gated by the enable bit.
    function automatic logic f_sig(input logic [15:0] c,
                                   input logic [2:0]  t);
        logic b;
        case (t[1:0])
            2'b00:   b = c[9];
            2'b01:   b = c[3];
            2'b10:   b = c[5];
            default: b = c[7];
        endcase
        return b & t[2];
    endfunction

    assign w_off = addr - BASE_ADDR;
    assign hit   = (w_off[15:2] == 14'd0);

    always_comb begin
        w_wr_div  = 1'b0;
        w_wr_tima = 1'b0;
        w_wr_tma  = 1'b0;
        w_wr_tac  = 1'b0;
        if (w_wen && hit) begin
            unique case (1'b1)
                (w_off[1:0] == 2'd0): w_wr_div  = 1'b1;
                (w_off[1:0] == 2'd1): w_wr_tima = 1'b1;
                (w_off[1:0] == 2'd2): w_wr_tma  = 1'b1;
                (w_off[1:0] == 2'd3): w_wr_tac  = 1'b1;
            endcase
        end
    end

    always_comb begin
        r_data = 8'h00;
        if (hit) begin
            case (w_off[1:0])
                2'd0:    r_data = r_cnt[15:8];
                2'd1:    r_data = r_tima;
                2'd2:    r_data = r_tma;
                default: r_data = {5'b11111, r_tac};
            endcase
        end
    end

    assign w_cnt_next = w_wr_div ? 16'h0000 : r_cnt + 16'(CNT_STEP);
    assign w_tac_next = w_wr_tac ? w_data[2:0] : r_tac;
    assign w_tma_next = w_wr_tma ? w_data : r_tma;

    // Falling edge of the gated tap; DIV/TAC writes can cause it.
    assign w_tick = f_sig(r_cnt, r_tac) & ~f_sig(w_cnt_next, w_tac_next);

    always_comb begin
        w_tima_next = r_tima;
        w_ovf_next  = 1'b0;
        w_irq_next  = 1'b0;
        if (r_ovf) begin
            // Reload cycle: a TIMA write cancels reload and irq,
            // and any tick here is swallowed.
            if (w_wr_tima) begin
                w_tima_next = w_data;
            end else begin
                w_tima_next = w_tma_next;
                w_irq_next  = 1'b1;
            end
        end else if (w_wr_tima) begin
            w_tima_next = w_data;
        end else if (w_tick) begin
            if (r_tima == 8'hFF) begin
                w_tima_next = 8'h00;
                w_ovf_next  = 1'b1;
            end else begin
                w_tima_next = r_tima + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 16'h0000;
            r_tima <= 8'h00;
            r_tma  <= 8'h00;
            r_tac  <= 3'b000;
            r_ovf  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tima <= w_tima_next;
            r_tma  <= w_tma_next;
            r_tac  <= w_tac_next;
            r_ovf  <= w_ovf_next;
            r_irq  <= w_irq_next;
        end
    end

    assign timer_irq = r_irq;

endmodule

// File: tb/tb_sm83_timer.sv
// Directed self-checking bench for sm83_timer.
// Hand-computed TIMA/DIV/TAC/irq expectations per cycle.
module tb_sm83_timer;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  w_data;
    logic        w_wen;
    logic [7:0]  r_data;
    logic        hit;
    logic        timer_irq;

    int total;
    int bad;

    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;

    sm83_timer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .w_data    (w_data),
        .w_wen     (w_wen),
        .r_data    (r_data),
        .hit       (hit),
        .timer_irq (timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic do_reset();
        rst_n  = 1'b0;
        addr   = 16'h0000;
        w_data = 8'h00;
        w_wen  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr   = a;
        w_data = d;
        w_wen  = 1'b1;
        @(posedge clk);
        #1;
        w_wen  = 1'b0;
        addr   = 16'h0000;
    endtask

    task automatic idle(input int n);
        w_wen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string tag,
                      input logic [15:0] a,
                      input logic [7:0] exp);
        addr  = a;
        w_wen = 1'b0;
        #1;
        chk(tag, {8'h00, r_data}, {8'h00, exp});
        addr = 16'h0000;
    endtask

    // Reset, then TIMA reaches 00 with ovf pending after edge 4.
    task automatic to_ovf(input logic [7:0] tma);
        do_reset();
        wr(A_TAC, 8'h05);
        wr(A_TMA, tma);
        wr(A_TIMA, 8'hFF);
        idle(1);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset state
        do_reset();
        rd("rst_div", A_DIV, 8'h00);
        rd("rst_tima", A_TIMA, 8'h00);
        rd("rst_tma", A_TMA, 8'h00);
        rd("rst_tac", A_TAC, 8'hF8);
        chk("rst_irq", {15'd0, timer_irq}, 16'd1 - 16'd1);

        // 1: FE -> FF -> 00 -> reload TMA(00) with one-clk irq
        do_reset();
        wr(A_TAC, 8'h05);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'hFE);
        rd("t1_tima_fe", A_TIMA, 8'hFE);
        idle(3);
        rd("t1_tima_ff", A_TIMA, 8'hFF);
        idle(3);
        rd("t1_tima_ff2", A_TIMA, 8'hFF);
        idle(1);
        rd("t1_tima_00", A_TIMA, 8'h00);
        chk("t1_irq_pre", {15'd0, timer_irq}, 16'd0);
        idle(1);
        rd("t1_reload", A_TIMA, 8'h00);
        chk("t1_irq_hi", {15'd0, timer_irq}, 16'd1);
        idle(1);
        chk("t1_irq_lo", {15'd0, timer_irq}, 16'd0);

        // 2: DIV write while tap bit is high causes a tick
        do_reset();
        wr(A_TAC, 8'h05);
        wr(A_TIMA, 8'h10);
        wr(A_DIV, 8'hAB);
        rd("t2_tima", A_TIMA, 8'h11);
        rd("t2_div", A_DIV, 8'h00);
        idle(1);
        rd("t2_tima_hold", A_TIMA, 8'h11);

        // 3: TIMA write in the 00 cycle cancels reload and irq
        to_ovf(8'h33);
        rd("t3_tima_00", A_TIMA, 8'h00);
        wr(A_TIMA, 8'h42);
        rd("t3_tima", A_TIMA, 8'h42);
        chk("t3_irq", {15'd0, timer_irq}, 16'd0);
        idle(1);
        rd("t3_tima_hold", A_TIMA, 8'h42);
        chk("t3_irq2", {15'd0, timer_irq}, 16'd0);

        // 3b: plain reload from stored TMA
        to_ovf(8'h33);
        idle(1);
        rd("t3b_reload", A_TIMA, 8'h33);
        chk("t3b_irq", {15'd0, timer_irq}, 16'd1);

        // 4: TMA write in reload cycle is used for the reload
        to_ovf(8'h33);
        wr(A_TMA, 8'h9C);
        rd("t4_tima", A_TIMA, 8'h9C);
        rd("t4_tma", A_TMA, 8'h9C);
        chk("t4_irq_hi", {15'd0, timer_irq}, 16'd1);
        idle(1);
        chk("t4_irq_lo", {15'd0, timer_irq}, 16'd0);
        rd("t4_tima_hold", A_TIMA, 8'h9C);

        // 5: TAC readback, unmapped addresses, disabled and mode 00
        do_reset();
        wr(A_TAC, 8'h02);
        rd("t5_tac", A_TAC, 8'hFA);
        addr = 16'hFF03;
        #1;
        chk("t5_hit_ff03", {15'd0, hit}, 16'd0);
        chk("t5_rd_ff03", {8'h00, r_data}, 16'h0000);
        addr = 16'hFF08;
        #1;
        chk("t5_hit_ff08", {15'd0, hit}, 16'd0);
        chk("t5_rd_ff08", {8'h00, r_data}, 16'h0000);
        addr = A_TMA;
        #1;
        chk("t5_hit_tma", {15'd0, hit}, 16'd1);
        wr(16'hFF03, 8'h55);
        wr(16'hFF08, 8'h77);
        rd("t5_tma_nw", A_TMA, 8'h00);
        rd("t5_tima_nw", A_TIMA, 8'h00);
        rd("t5_tac_nw", A_TAC, 8'hFA);
        idle(20);
        rd("t5_dis", A_TIMA, 8'h00);

        do_reset();
        wr(A_TAC, 8'h04);
        idle(254);
        rd("t5_m0_255", A_TIMA, 8'h00);
        idle(1);
        rd("t5_m0_256", A_TIMA, 8'h01);
        idle(255);
        rd("t5_m0_511", A_TIMA, 8'h01);
        idle(1);
        rd("t5_m0_512", A_TIMA, 8'h02);
        rd("t5_div", A_DIV, 8'h08);

        // 6: async reset while overflow is pending
        to_ovf(8'h33);
        rd("t6_pre", A_TAC, 8'hFD);
        rst_n = 1'b0;
        #1;
        rd("t6_tima", A_TIMA, 8'h00);
        rd("t6_tac", A_TAC, 8'hF8);
        chk("t6_irq", {15'd0, timer_irq}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        chk("t6_irq_a", {15'd0, timer_irq}, 16'd0);
        rd("t6_tima_a", A_TIMA, 8'h00);
        idle(1);
        chk("t6_irq_b", {15'd0, timer_irq}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
